// File: rtl/m_dbus_ctrl_if.sv
// Data-bus handshake bundle between the M-stage controller (master) and the
// memory slave. One valid/ready transaction at a time; rdata/err qualify with ready.
interface m_dbus_ctrl_if;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wen;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_valid, bus_addr, bus_wen, bus_wdata,
    input  bus_ready, bus_rdata, bus_err
  );

  modport slave (
    input  bus_valid, bus_addr, bus_wen, bus_wdata,
    output bus_ready, bus_rdata, bus_err
  );
endinterface

// File: rtl/m_dbus_ctrl.sv
// M-stage data-bus controller: launches one load or store per instruction on
// the valid/ready bus, stalls the pipeline until it completes, returns the raw
// read word and flags slave errors / timeouts for the exception logic.
module m_dbus_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic [31:0]       addr,
  input  logic [3:0]        ByteEn,
  input  logic [31:0]       WDin,
  input  logic              req,
  output logic              stall,
  output logic [31:0]       RDout,
  output logic              rd_valid,
  output logic              acc_err,
  m_dbus_ctrl_if.master     bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  // Counter value seen on the last permitted waiting cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q,     state_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic        bus_valid_q, bus_valid_d;
  logic [31:0] bus_addr_q,  bus_addr_d;
  logic [3:0]  bus_wen_q,   bus_wen_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdout_q,     rdout_d;
  logic        rd_valid_q,  rd_valid_d;
  logic        acc_err_q,   acc_err_d;
  logic        start;

  // Byte offset is irrelevant on a word-addressed bus; lanes come from ByteEn.
  logic addr_lo_unused;
  assign addr_lo_unused = ^addr[1:0];

  assign start = (state_q == S_IDLE) && (mem_rd || (|ByteEn)) && !req;

  assign stall         = start || (state_q == S_REQ);
  assign RDout         = rdout_q;
  assign rd_valid      = rd_valid_q;
  assign acc_err       = acc_err_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wen   = bus_wen_q;
  assign bus.bus_wdata = bus_wdata_q;

  // Next-state and next-output computation for the IDLE/REQ/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    bus_wen_d   = bus_wen_q;
    bus_wdata_d = bus_wdata_q;
    rdout_d     = rdout_q;
    rd_valid_d  = 1'b0;
    acc_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_REQ;
          bus_valid_d = 1'b1;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_wen_d   = ByteEn;
          bus_wdata_d = WDin;
          cnt_d       = 8'd0;
        end
      end
      S_REQ: begin
        if (bus.bus_ready) begin
          // Completion beats a coincident timeout.
          state_d     = S_DONE;
          bus_valid_d = 1'b0;
          bus_wen_d   = 4'b0000;
          if (bus.bus_err) begin
            acc_err_d = 1'b1;
            rdout_d   = 32'd0;
          end else if (bus_wen_q == 4'b0000) begin
            // Only a pure load returns data; a store that also had mem_rd drops it.
            rdout_d    = bus.bus_rdata;
            rd_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          bus_valid_d = 1'b0;
          acc_err_d   = 1'b1;
          rdout_d     = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        // Inputs are still those of the finished instruction; never restart here.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wen_q   <= 4'b0000;
      bus_wdata_q <= 32'd0;
      rdout_q     <= 32'd0;
      rd_valid_q  <= 1'b0;
      acc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_wen_q   <= bus_wen_d;
      bus_wdata_q <= bus_wdata_d;
      rdout_q     <= rdout_d;
      rd_valid_q  <= rd_valid_d;
      acc_err_q   <= acc_err_d;
    end
  end

endmodule

// File: tb/tb_m_dbus_ctrl.sv
// Bench for m_dbus_ctrl: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_m_dbus_ctrl;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd;
  logic [31:0] addr;
  logic [3:0]  ByteEn;
  logic [31:0] WDin;
  logic        req;
  logic        stall;
  logic [31:0] RDout;
  logic        rd_valid;
  logic        acc_err;

  m_dbus_ctrl_if bus_if ();

  m_dbus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_rd   (mem_rd),
    .addr     (addr),
    .ByteEn   (ByteEn),
    .WDin     (WDin),
    .req      (req),
    .stall    (stall),
    .RDout    (RDout),
    .rd_valid (rd_valid),
    .acc_err  (acc_err),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0 = no transaction, 1 = on the bus, 2 = finished.
  int          m_phase;
  int          m_waited;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [3:0]  m_wen;
  bit          m_load, m_rdv, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_waited = 0;
    m_addr = '0; m_wdata = '0; m_rd = '0; m_wen = '0;
    m_load = 0; m_rdv = 0; m_err = 0;
  endtask

  task automatic compare_outputs();
    bit wants = mem_rd || (ByteEn != 4'b0000);
    bit exp_stall = (m_phase == 1) || (m_phase == 0 && wants && !req);
    check("stall", stall, exp_stall);
    check("bus_valid", bus_if.bus_valid, m_phase == 1);
    check("rd_valid", rd_valid, m_rdv);
    check("acc_err", acc_err, m_err);
    check("RDout", RDout, m_rd);
    if (m_phase == 1) begin
      check("bus_addr", bus_if.bus_addr, m_addr);
      check("bus_wen", bus_if.bus_wen, m_wen);
      check("bus_wdata", bus_if.bus_wdata, m_wdata);
    end
  endtask

  task automatic model_update();
    if (!reset) begin
      model_reset();
    end else begin
      case (m_phase)
        0: begin
          m_rdv = 0; m_err = 0;
          if ((mem_rd || ByteEn != 4'b0000) && !req) begin
            m_phase  = 1;
            m_waited = 0;
            m_addr   = {addr[31:2], 2'b00};
            m_wen    = ByteEn;
            m_wdata  = WDin;
            m_load   = (ByteEn == 4'b0000);
          end
        end
        1: begin
          m_waited++;
          if (bus_if.bus_ready) begin
            m_phase = 2;
            if (bus_if.bus_err) begin
              m_err = 1; m_rd = 32'd0;
            end else if (m_load) begin
              m_rd = bus_if.bus_rdata; m_rdv = 1;
            end
          end else if (m_waited == TIMEOUT) begin
            m_phase = 2; m_err = 1; m_rd = 32'd0;
          end
        end
        default: begin
          m_phase = 0; m_rdv = 0; m_err = 0;
        end
      endcase
    end
  endtask

  task automatic cyc_a();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic cyc_b();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    cyc_a();
    cyc_b();
  endtask

  task automatic clear_inputs();
    mem_rd = 0; ByteEn = 4'b0000; req = 0; addr = '0; WDin = '0;
    bus_if.bus_ready = 0; bus_if.bus_err = 0;
  endtask

  // Runs one instruction already presented on the inputs until its DONE cycle.
  task automatic run_txn(input int ready_at, input bit err, input logic [31:0] rdata,
                         input bit raise_req, output int n_stall, output int n_valid,
                         output bit got_rdv, output bit got_err, output logic [31:0] got_rd);
    bit done = 0;
    n_stall = 0; n_valid = 0; got_rdv = 0; got_err = 0; got_rd = '0;
    for (int c = 0; c < TIMEOUT + 10 && !done; c++) begin
      cyc_a();
      if (stall) n_stall++;
      if (bus_if.bus_valid) begin
        n_valid++;
        if (raise_req) req = 1;
      end
      if (!stall && n_stall > 0) begin
        done = 1; got_rdv = rd_valid; got_err = acc_err; got_rd = RDout;
      end
      bus_if.bus_ready = bus_if.bus_valid && (n_valid == ready_at);
      bus_if.bus_err   = bus_if.bus_ready && err;
      bus_if.bus_rdata = rdata;
      cyc_b();
    end
    clear_inputs();
    if (!done) check("txn_bound", 0, 1);
  endtask

  initial begin
    int ns, nv, nrd, deaf;
    bit rv, ae;
    logic [31:0] rd, data;

    reset = 0;
    clear_inputs();
    bus_if.bus_rdata = '0;
    model_reset();
    cyc_b();
    cyc_b();
    cyc_a();
    check("rst_stall", stall, 0);
    check("rst_bus_valid", bus_if.bus_valid, 0);
    check("rst_bus_addr", bus_if.bus_addr, 0);
    check("rst_bus_wen", bus_if.bus_wen, 0);
    check("rst_bus_wdata", bus_if.bus_wdata, 0);
    check("rst_RDout", RDout, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_acc_err", acc_err, 0);
    reset = 1;
    cyc_b();

    // Zero-wait load
    mem_rd = 1; addr = 32'h0000_1006;
    cyc_a(); check("t1_start_stall", stall, 1); cyc_b();
    bus_if.bus_ready = 1; bus_if.bus_rdata = 32'hDEAD_BEEF;
    cyc_a();
    check("t1_valid", bus_if.bus_valid, 1);
    check("t1_addr", bus_if.bus_addr, 32'h0000_1004);
    check("t1_wen", bus_if.bus_wen, 4'b0000);
    check("t1_req_stall", stall, 1);
    cyc_b();
    bus_if.bus_ready = 0;
    cyc_a();
    check("t1_rd_valid", rd_valid, 1);
    check("t1_RDout", RDout, 32'hDEAD_BEEF);
    check("t1_done_stall", stall, 0);
    check("t1_acc_err", acc_err, 0);
    cyc_b();
    clear_inputs();
    cyc();

    // Store with three wait states
    ByteEn = 4'b0100; WDin = 32'h00AB_0000; addr = 32'h0000_2002;
    run_txn(4, 0, 32'h5555_5555, 0, ns, nv, rv, ae, rd);
    check("t2_valid_cycles", nv, 4);
    check("t2_stall_cycles", ns, 5);
    check("t2_acc_err", ae, 0);
    check("t2_rd_valid", rv, 0);

    // Timeout, then a normal load
    mem_rd = 1; addr = 32'h0000_3000;
    run_txn(-1, 0, 32'h1111_1111, 0, ns, nv, rv, ae, rd);
    check("t3_valid_cycles", nv, TIMEOUT);
    check("t3_stall_cycles", ns, TIMEOUT + 1);
    check("t3_acc_err", ae, 1);
    check("t3_RDout", rd, 0);
    check("t3_rd_valid", rv, 0);
    mem_rd = 1; addr = 32'h0000_3004;
    run_txn(1, 0, 32'hCAFE_F00D, 0, ns, nv, rv, ae, rd);
    check("t3b_stall_cycles", ns, 2);
    check("t3b_RDout", rd, 32'hCAFE_F00D);
    check("t3b_rd_valid", rv, 1);

    // Slave error, then ready exactly on the timeout edge
    mem_rd = 1; addr = 32'h0000_4008;
    run_txn(2, 1, 32'h1234_5678, 0, ns, nv, rv, ae, rd);
    check("t4_acc_err", ae, 1);
    check("t4_rd_valid", rv, 0);
    check("t4_RDout", rd, 0);
    check("t4_stall_cycles", ns, 3);
    mem_rd = 1; addr = 32'h0000_400C;
    run_txn(TIMEOUT, 0, 32'h0BAD_CAFE, 0, ns, nv, rv, ae, rd);
    check("t4b_valid_cycles", nv, TIMEOUT);
    check("t4b_acc_err", ae, 0);
    check("t4b_rd_valid", rv, 1);
    check("t4b_RDout", rd, 32'h0BAD_CAFE);

    // Suppression in IDLE, then req rising mid-transaction
    req = 1; ByteEn = 4'b1111; WDin = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      cyc_a();
      check("t5_supp_stall", stall, 0);
      check("t5_supp_valid", bus_if.bus_valid, 0);
      cyc_b();
    end
    clear_inputs();
    ByteEn = 4'b0011; WDin = 32'h0000_BEEF; addr = 32'h0000_6000;
    run_txn(3, 0, 32'h0, 1, ns, nv, rv, ae, rd);
    check("t5_valid_cycles", nv, 3);
    check("t5_acc_err", ae, 0);

    // Reset in the middle of a waiting transaction
    mem_rd = 1; addr = 32'h0000_7000;
    cyc(); cyc();
    cyc_a(); reset = 0; mem_rd = 0; cyc_b();
    reset = 1;
    cyc_a();
    check("t6_valid", bus_if.bus_valid, 0);
    check("t6_stall", stall, 0);
    check("t6_addr", bus_if.bus_addr, 0);
    check("t6_wen", bus_if.bus_wen, 0);
    check("t6_wdata", bus_if.bus_wdata, 0);
    check("t6_RDout", RDout, 0);
    check("t6_rd_valid", rd_valid, 0);
    check("t6_acc_err", acc_err, 0);
    cyc_b();

    // Back-to-back loads with an always-ready slave: three cycles each
    mem_rd = 1; addr = 32'h0000_8000; bus_if.bus_ready = 1;
    nv = 0; nrd = 0;
    for (int i = 0; i < 9; i++) begin
      bus_if.bus_rdata = 32'hA000_0000 + i;
      cyc_a();
      if (bus_if.bus_valid) nv++;
      if (rd_valid) nrd++;
      cyc_b();
    end
    check("t6_b2b_valid", nv, 3);
    check("t6_b2b_rdv", nrd, 3);
    clear_inputs();
    cyc();

    // Random traffic against the model
    deaf = 0;
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom % 60) != 0;
      mem_rd = $urandom % 2;
      ByteEn = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0000;
      req    = ($urandom % 5) == 0;
      addr   = $urandom;
      WDin   = $urandom;
      if (deaf == 0 && ($urandom % 40) == 0) deaf = 25;
      bus_if.bus_ready = (deaf > 0) ? 1'b0 : (($urandom % 3) == 0);
      bus_if.bus_err   = ($urandom % 6) == 0;
      data = $urandom;
      bus_if.bus_rdata = data;
      if (deaf > 0) deaf--;
      cyc();
    end

    reset = 1;
    clear_inputs();
    cyc(); cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
